ysyx_23060184_pcgen: RTL and testbench

Parametrised PC generator with handshakes to the IFU and the WBU. It issues fetch addresses to the IFU and tracks up to DEPTH outstanding instructions in an in-order queue. When the WBU returns each instruction's next PC, the block checks it against sequential prediction and redirects on mismatch. External redirects (trap/mret) take priority. Sits at the head of the fetch pipeline.

---
 rtl/ysyx_23060184_pcgen.sv | 144 ++++++++++++++
 tb/tb_ysyx_23060184_pcgen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_pcgen.sv
// PC generator: issues fetch addresses, tracks in-flight PCs,
// verifies retired next-PCs and redirects on mismatch or trap.
module ysyx_23060184_pcgen #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VEC  = 32'h80000000,
   parameter int unsigned           INST_BYTES = 4,
   parameter int unsigned           DEPTH      = 4,
   parameter bit                    PREFETCH   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rstn,
   output logic                       pc_valid,
   input  logic                       pc_ready,
   output logic [DATA_WIDTH-1:0]      pc,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [DATA_WIDTH-1:0]      wb_npc,
   input  logic                       redir_valid,
   input  logic [DATA_WIDTH-1:0]      redir_pc,
   output logic                       flush,
   output logic [$clog2(DEPTH):0]     outstanding
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0] LIM =
      PREFETCH ? CW'(DEPTH) : CW'(1);

   localparam logic [DATA_WIDTH-1:0] INC =
      DATA_WIDTH'(INST_BYTES);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pc_d;
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         head_d;
   logic [PW-1:0]         tail_q;
   logic [PW-1:0]         tail_d;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  flush_q;
   logic                  flush_d;
   logic                  enq;

   logic [DATA_WIDTH-1:0] q_mem [DEPTH];
   logic [DATA_WIDTH-1:0] head_pc;
   logic [DATA_WIDTH-1:0] exp_npc;

   logic issue;
   logic retire;
   logic mis;

   assign pc_valid = rstn && !flush_q
                     && (count_q < LIM);

   assign wb_ready = (count_q != '0) && !flush_q;

   assign issue  = pc_valid && pc_ready;
   assign retire = wb_valid && wb_ready;

   assign head_pc = q_mem[head_q];
   assign exp_npc = head_pc + INC;

   // Only speculative mode can mispredict;
   // legacy mode just takes wb_npc as the next PC.
   assign mis = PREFETCH && retire
                && (wb_npc != exp_npc);

   assign pc          = pc_q;
   assign flush       = flush_q;
   assign outstanding = count_q;

   // Next-state: redirect beats mismatch beats bookkeeping.
   // Any redirect or mismatch drops a same-cycle issue.
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      flush_d = 1'b0;
      enq     = 1'b0;
      if (redir_valid) begin
         pc_d    = redir_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         flush_d = 1'b1;
      end else if (mis) begin
         pc_d    = wb_npc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         flush_d = 1'b1;
      end else if (PREFETCH) begin
         if (issue) begin
            enq    = 1'b1;
            tail_d = tail_q + PW'(1);
            pc_d   = pc_q + INC;
         end
         if (retire) begin
            head_d = head_q + PW'(1);
         end
         unique case ({issue, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end else begin
         if (issue) begin
            enq     = 1'b1;
            count_d = CW'(1);
         end
         if (retire) begin
            pc_d    = wb_npc;
            count_d = '0;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q    <= RESET_VEC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         flush_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         flush_q <= flush_d;
      end
   end

   // Issued-PC storage; entries are only read while valid.
   always_ff @(posedge clk) begin
      if (rstn && enq) begin
         q_mem[tail_q] <= pc_q;
      end
   end

endmodule

// File: tb/tb_ysyx_23060184_pcgen.sv
// Directed bench for the PC generator: streaming, mispredict,
// redirect, wrap, legacy mode and mid-stream reset.
module tb_ysyx_23060184_pcgen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: default configuration.
   logic        a_rstn, a_pc_valid, a_pc_ready;
   logic [31:0] a_pc, a_wb_npc, a_redir_pc;
   logic        a_wb_valid, a_wb_ready, a_redir_valid;
   logic        a_flush;
   logic [2:0]  a_out;

   // Instance W: wrap-around reset vector.
   logic        w_rstn, w_pc_valid, w_pc_ready;
   logic [31:0] w_pc, w_wb_npc, w_redir_pc;
   logic        w_wb_valid, w_wb_ready, w_redir_valid;
   logic        w_flush;
   logic [2:0]  w_out;

   // Instance L: legacy single-outstanding mode.
   logic        l_rstn, l_pc_valid, l_pc_ready;
   logic [31:0] l_pc, l_wb_npc, l_redir_pc;
   logic        l_wb_valid, l_wb_ready, l_redir_valid;
   logic        l_flush;
   logic [2:0]  l_out;
   logic        l_flush_seen = 1'b0;

   ysyx_23060184_pcgen u_a (
      .clk(clk), .rstn(a_rstn),
      .pc_valid(a_pc_valid), .pc_ready(a_pc_ready),
      .pc(a_pc), .wb_valid(a_wb_valid),
      .wb_ready(a_wb_ready), .wb_npc(a_wb_npc),
      .redir_valid(a_redir_valid), .redir_pc(a_redir_pc),
      .flush(a_flush), .outstanding(a_out)
   );

   ysyx_23060184_pcgen #(.RESET_VEC(32'hFFFFFFF8)) u_w (
      .clk(clk), .rstn(w_rstn),
      .pc_valid(w_pc_valid), .pc_ready(w_pc_ready),
      .pc(w_pc), .wb_valid(w_wb_valid),
      .wb_ready(w_wb_ready), .wb_npc(w_wb_npc),
      .redir_valid(w_redir_valid), .redir_pc(w_redir_pc),
      .flush(w_flush), .outstanding(w_out)
   );

   ysyx_23060184_pcgen #(.PREFETCH(1'b0)) u_l (
      .clk(clk), .rstn(l_rstn),
      .pc_valid(l_pc_valid), .pc_ready(l_pc_ready),
      .pc(l_pc), .wb_valid(l_wb_valid),
      .wb_ready(l_wb_ready), .wb_npc(l_wb_npc),
      .redir_valid(l_redir_valid), .redir_pc(l_redir_pc),
      .flush(l_flush), .outstanding(l_out)
   );

   // Record any flush from the legacy instance.
   always @(posedge clk) begin
      if (l_rstn && l_flush) l_flush_seen <= 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   initial begin
      a_rstn = 0; a_pc_ready = 0; a_wb_valid = 0;
      a_wb_npc = 0; a_redir_valid = 0; a_redir_pc = 0;
      w_rstn = 0; w_pc_ready = 0; w_wb_valid = 0;
      w_wb_npc = 0; w_redir_valid = 0; w_redir_pc = 0;
      l_rstn = 0; l_pc_ready = 0; l_wb_valid = 0;
      l_wb_npc = 0; l_redir_valid = 0; l_redir_pc = 0;

      // ---- A: reset state
      tick();
      chk("a_rst_pc", a_pc, 32'h80000000);
      chk("a_rst_valid", 32'(a_pc_valid), 0);
      chk("a_rst_wbrdy", 32'(a_wb_ready), 0);
      chk("a_rst_out", 32'(a_out), 0);
      chk("a_rst_flush", 32'(a_flush), 0);
      a_rstn = 1; a_pc_ready = 1;
      #1;
      chk("a_rel_valid", 32'(a_pc_valid), 1);

      // ---- A: streaming until full
      tick();
      chk("a_s1_pc", a_pc, 32'h80000004);
      chk("a_s1_valid", 32'(a_pc_valid), 1);
      tick();
      tick();
      chk("a_s3_pc", a_pc, 32'h8000000C);
      chk("a_s3_out", 32'(a_out), 3);
      chk("a_s3_valid", 32'(a_pc_valid), 1);
      tick();
      chk("a_full_pc", a_pc, 32'h80000010);
      chk("a_full_out", 32'(a_out), 4);
      chk("a_full_valid", 32'(a_pc_valid), 0);
      a_wb_valid = 1; a_wb_npc = 32'h80000004;
      tick();
      chk("a_ret_out", 32'(a_out), 3);
      chk("a_ret_valid", 32'(a_pc_valid), 1);
      chk("a_ret_flush", 32'(a_flush), 0);
      chk("a_ret_pc", a_pc, 32'h80000010);
      a_wb_valid = 0;
      tick();
      chk("a_refill_out", 32'(a_out), 4);
      chk("a_refill_pc", a_pc, 32'h80000014);

      // ---- A: retire then reset mid-stream
      a_pc_ready = 0;
      a_wb_valid = 1; a_wb_npc = 32'h80000008;
      tick();
      chk("a_pre_rst_out", 32'(a_out), 3);
      a_rstn = 0; a_wb_npc = 32'h80000999;
      tick();
      chk("a_mrst_out", 32'(a_out), 0);
      chk("a_mrst_pc", a_pc, 32'h80000000);
      chk("a_mrst_flush", 32'(a_flush), 0);
      chk("a_mrst_valid", 32'(a_pc_valid), 0);
      chk("a_mrst_wbrdy", 32'(a_wb_ready), 0);
      a_rstn = 1; a_wb_valid = 0; a_pc_ready = 1;
      #1;
      chk("a_mrel_valid", 32'(a_pc_valid), 1);

      // ---- A: mispredict with 3 outstanding
      tick();
      tick();
      tick();
      chk("a_m_out3", 32'(a_out), 3);
      a_pc_ready = 0;
      a_wb_valid = 1; a_wb_npc = 32'h80000100;
      tick();
      chk("a_mis_flush", 32'(a_flush), 1);
      chk("a_mis_out", 32'(a_out), 0);
      chk("a_mis_pc", a_pc, 32'h80000100);
      chk("a_mis_valid", 32'(a_pc_valid), 0);
      chk("a_mis_wbrdy", 32'(a_wb_ready), 0);
      a_wb_valid = 0; a_pc_ready = 1;
      tick();
      chk("a_mis2_flush", 32'(a_flush), 0);
      chk("a_mis2_valid", 32'(a_pc_valid), 1);
      chk("a_mis2_pc", a_pc, 32'h80000100);
      tick();
      tick();
      chk("a_pre_col_out", 32'(a_out), 2);

      // ---- A: redirect colliding with mismatching retire
      a_pc_ready = 0;
      a_redir_valid = 1; a_redir_pc = 32'h80000200;
      a_wb_valid = 1; a_wb_npc = 32'h80000300;
      tick();
      chk("a_col_pc", a_pc, 32'h80000200);
      chk("a_col_flush", 32'(a_flush), 1);
      chk("a_col_out", 32'(a_out), 0);
      a_wb_valid = 0; a_redir_valid = 0;
      tick();
      chk("a_col2_flush", 32'(a_flush), 0);
      chk("a_col2_pc", a_pc, 32'h80000200);

      // ---- A: redirect arriving during a flush cycle
      a_redir_valid = 1; a_redir_pc = 32'h80000300;
      tick();
      chk("a_rf1_flush", 32'(a_flush), 1);
      a_redir_pc = 32'h80000400;
      tick();
      chk("a_rf2_flush", 32'(a_flush), 1);
      chk("a_rf2_pc", a_pc, 32'h80000400);
      a_redir_valid = 0;
      tick();
      chk("a_rf3_flush", 32'(a_flush), 0);
      chk("a_rf3_valid", 32'(a_pc_valid), 1);
      chk("a_rf3_pc", a_pc, 32'h80000400);

      // ---- A: issue in the same cycle as a redirect
      a_pc_ready = 1;
      a_redir_valid = 1; a_redir_pc = 32'h80000500;
      tick();
      chk("a_ir_out", 32'(a_out), 0);
      chk("a_ir_pc", a_pc, 32'h80000500);
      chk("a_ir_flush", 32'(a_flush), 1);
      a_redir_valid = 0; a_pc_ready = 0;

      // ---- W: address wrap
      tick();
      w_rstn = 1; w_pc_ready = 1;
      #1;
      chk("w_rel_pc", w_pc, 32'hFFFFFFF8);
      tick();
      chk("w_i1_pc", w_pc, 32'hFFFFFFFC);
      tick();
      chk("w_i2_pc", w_pc, 32'h00000000);
      chk("w_i2_out", 32'(w_out), 2);
      w_pc_ready = 0;
      w_wb_valid = 1; w_wb_npc = 32'hFFFFFFFC;
      tick();
      chk("w_ret_flush", 32'(w_flush), 0);
      chk("w_ret_out", 32'(w_out), 1);
      w_wb_valid = 0;

      // ---- L: legacy single-outstanding mode
      tick();
      l_rstn = 1; l_pc_ready = 1;
      #1;
      chk("l_rel_valid", 32'(l_pc_valid), 1);
      chk("l_rel_pc", l_pc, 32'h80000000);
      tick();
      chk("l_i1_valid", 32'(l_pc_valid), 0);
      chk("l_i1_pc", l_pc, 32'h80000000);
      chk("l_i1_out", 32'(l_out), 1);
      tick();
      chk("l_wait_valid", 32'(l_pc_valid), 0);
      l_wb_valid = 1; l_wb_npc = 32'h80000010;
      tick();
      chk("l_ret_pc", l_pc, 32'h80000010);
      chk("l_ret_valid", 32'(l_pc_valid), 1);
      chk("l_ret_out", 32'(l_out), 0);
      chk("l_ret_flush", 32'(l_flush), 0);
      l_wb_valid = 0;
      tick();
      chk("l_i2_out", 32'(l_out), 1);
      chk("l_i2_pc", l_pc, 32'h80000010);
      chk("l_noflush", 32'(l_flush_seen), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
